// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX/MEM pipeline register with a 2-entry skid buffer, flush, x0 write suppression,
// forwarding tap and saturating stall counter.
module ex_mem_skid #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int EXTRA_W = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ADDR_W-1:0]  in_rd,
   input  logic               in_wreg,
   input  logic [DATA_W-1:0]  in_wdata,
   input  logic [EXTRA_W-1:0] in_extra,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_rd,
   output logic               out_wreg,
   output logic [DATA_W-1:0]  out_wdata,
   output logic [EXTRA_W-1:0] out_extra,
   output logic               fwd_valid,
   output logic [ADDR_W-1:0]  fwd_rd,
   output logic [DATA_W-1:0]  fwd_wdata,
   output logic [CNT_W-1:0]   stall_cnt
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   typedef struct packed {
      logic [ADDR_W-1:0]  rd;
      logic               wreg;
      logic [DATA_W-1:0]  wdata;
      logic [EXTRA_W-1:0] extra;
   } slot_t;
   state_t            state_q, state_d;
   slot_t             main_q, main_d, skid_q, skid_d, in_slot;
   logic              in_ready_q;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              in_fire, out_fire;
   // in_ready is a register so it stays low through reset and never depends on out_ready
   assign in_ready  = in_ready_q;
   assign out_valid = state_q != EMPTY;
   assign in_fire   = in_valid & in_ready_q;
   assign out_fire  = out_valid & out_ready;
   assign in_slot   = '{rd: in_rd, wreg: in_wreg & (in_rd != '0), wdata: in_wdata, extra: in_extra};
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         case (state_q)
            EMPTY: if (in_fire) begin
               state_d = ONE;
               main_d  = in_slot;
            end
            ONE: if (in_fire && out_fire) begin
               main_d = in_slot;
            end else if (in_fire) begin
               state_d = FULL;
               skid_d  = in_slot;
            end else if (out_fire) begin
               state_d = EMPTY;
               main_d  = '0;
            end
            FULL: if (out_fire) begin
               state_d = ONE;
               main_d  = skid_q;
               skid_d  = '0;
            end
            default: begin
               state_d = EMPTY;
               main_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end
   assign stall_d = (out_valid && !out_ready && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= state_d != FULL;
         stall_q    <= stall_d;
      end
   end
   assign out_rd    = out_valid ? main_q.rd    : '0;
   assign out_wreg  = out_valid & main_q.wreg;
   assign out_wdata = out_valid ? main_q.wdata : '0;
   assign out_extra = out_valid ? main_q.extra : '0;
   assign fwd_valid = out_valid & out_wreg;
   assign fwd_rd    = out_rd;
   assign fwd_wdata = out_wdata;
   assign stall_cnt = stall_q;
endmodule
